// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with manual, round-robin and fixed-priority
// arbitration feeding a single-entry output register tagged with the source channel.
module stream_mux_arb #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [1:0] MODE_RR  = 2'b01;
    localparam logic [1:0] MODE_FIX = 2'b10;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             load_en;
    logic             any_grant;
    logic [N-1:0]     grant;
    logic [N-1:0]     first_mask;
    logic [N-1:0]     wrap_mask;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !out_valid_q || out_ready;

    // Every mode reduces to a two-pass lowest-index scan: first_mask is searched
    // before wrap_mask, which lets round-robin wrap past N-1 without a rotator.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        first_mask = '0;
        wrap_mask  = '0;
        any_grant  = 1'b0;
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;

        case (mode)
            MODE_RR: begin
                for (int c = 0; c < N; c++) begin
                    first_mask[c] = in_valid[c] && (c >= int'(rr_ptr_q));
                end
                wrap_mask = in_valid;
            end
            MODE_FIX: first_mask = in_valid;
            default: begin
                for (int c = 0; c < N; c++) begin
                    first_mask[c] = in_valid[c] && (sel == SEL_W'(c));
                end
            end
        endcase

        for (int c = 0; c < N; c++) begin
            if (!any_grant && first_mask[c]) begin
                any_grant  = 1'b1;
                grant[c]   = 1'b1;
                grant_idx  = SEL_W'(c);
                grant_data = in_data[c*WIDTH +: WIDTH];
            end
        end
        for (int c = 0; c < N; c++) begin
            if (!any_grant && wrap_mask[c]) begin
                any_grant  = 1'b1;
                grant[c]   = 1'b1;
                grant_idx  = SEL_W'(c);
                grant_data = in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = grant & {N{load_en}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;

        if (load_en) begin
            // A granted channel is always valid, so grant plus load_en is a transfer.
            out_valid_d = any_grant;
            if (any_grant) begin
                out_data_d = grant_data;
                out_chan_d = grant_idx;
                if (mode == MODE_RR) begin
                    rr_ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
